// File: rtl/plane_write_sequencer.sv
// Sequences auto-increment, set-address and data writes onto the LED-plane
// controller's byte bus, holding dataIn/rs stable around each dataEn fall.
module plane_write_sequencer #(
  parameter int D_WIDTH   = 8,
  parameter int A_WIDTH   = 6,
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startValid,
  input  logic [A_WIDTH-1:0] startAddr,
  input  logic [A_WIDTH:0]   startLen,
  input  logic               clearReq,
  input  logic [D_WIDTH-1:0] byteIn,
  input  logic               byteValid,
  output logic               byteReady,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] dataIn,
  output logic               dataEn,
  output logic               rs
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_INC, S_ADDR, S_WAIT, S_DATA, S_DONE
  } state_t;

  localparam logic [D_WIDTH-1:0] LP_CMD_CLR  = D_WIDTH'(8'h01);
  localparam logic [D_WIDTH-1:0] LP_CMD_INC  = D_WIDTH'(8'h06);
  localparam logic [D_WIDTH-1:0] LP_CMD_ADDR = D_WIDTH'(8'h80);
  localparam logic [4:0]         LP_HI       = 5'(STROBE_HI);
  localparam logic [4:0]         LP_LAST     = 5'(STROBE_HI + STROBE_LO - 1);

  state_t             r_state;
  logic [4:0]         r_cnt;
  logic [A_WIDTH-1:0] r_addr;
  logic [A_WIDTH:0]   r_len;
  logic [D_WIDTH-1:0] r_data_in;
  logic               r_data_en;
  logic               r_rs;

  state_t             w_state_next;
  logic [4:0]         w_cnt_next;
  logic [4:0]         w_cnt_inc;
  logic               w_xfer_last;
  logic [A_WIDTH-1:0] w_addr_next;
  logic [A_WIDTH:0]   w_len_next;
  logic [D_WIDTH-1:0] w_data_in_next;
  logic               w_data_en_next;
  logic               w_rs_next;
  logic [D_WIDTH-1:0] w_addr_cmd;

  assign w_cnt_inc   = r_cnt + 5'd1;
  assign w_xfer_last = (r_cnt == LP_LAST);
  assign w_addr_cmd  = LP_CMD_ADDR | D_WIDTH'(r_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_data_in <= '0;
      r_data_en <= 1'b0;
      r_rs      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_addr    <= w_addr_next;
      r_len     <= w_len_next;
      r_data_in <= w_data_in_next;
      r_data_en <= w_data_en_next;
      r_rs      <= w_rs_next;
    end
  end

  // Starting a transfer loads strobe, select and data together on the same
  // edge; inside a transfer the phase counter alone shapes dataEn.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_addr_next    = r_addr;
    w_len_next     = r_len;
    w_data_in_next = r_data_in;
    w_data_en_next = 1'b0;
    w_rs_next      = r_rs;
    byteReady      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (clearReq) begin
          w_state_next   = S_CLR;
          w_cnt_next     = '0;
          w_data_en_next = 1'b1;
          w_rs_next      = 1'b1;
          w_data_in_next = LP_CMD_CLR;
        end else if (startValid) begin
          w_addr_next = startAddr;
          w_len_next  = startLen;
          if (startLen == '0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next   = S_INC;
            w_cnt_next     = '0;
            w_data_en_next = 1'b1;
            w_rs_next      = 1'b1;
            w_data_in_next = LP_CMD_INC;
          end
        end
      end

      S_CLR, S_INC, S_ADDR, S_DATA: begin
        busy           = 1'b1;
        w_cnt_next     = w_cnt_inc;
        w_data_en_next = (w_cnt_inc < LP_HI);
        if (w_xfer_last) begin
          w_cnt_next     = '0;
          w_data_en_next = 1'b0;
          case (r_state)
            S_CLR:  w_state_next = S_DONE;
            S_INC: begin
              w_state_next   = S_ADDR;
              w_data_en_next = 1'b1;
              w_rs_next      = 1'b1;
              w_data_in_next = w_addr_cmd;
            end
            S_ADDR: w_state_next = S_WAIT;
            default: begin
              w_len_next   = r_len - (A_WIDTH+1)'(1);
              w_state_next = (r_len == (A_WIDTH+1)'(1)) ? S_DONE : S_WAIT;
            end
          endcase
        end
      end

      S_WAIT: begin
        busy      = 1'b1;
        byteReady = 1'b1;
        if (byteValid) begin
          w_state_next   = S_DATA;
          w_cnt_next     = '0;
          w_data_en_next = 1'b1;
          w_rs_next      = 1'b0;
          w_data_in_next = byteIn;
        end
      end

      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign dataIn = r_data_in;
  assign dataEn = r_data_en;
  assign rs     = r_rs;

endmodule

// File: tb/tb_plane_write_sequencer.sv
// Directed bench for plane_write_sequencer: bus monitor with a falling-edge
// plane-memory model, timing checks and per-scenario expected values.
module tb_plane_write_sequencer;

  logic       clk;
  logic       reset;
  logic       startValid;
  logic [5:0] startAddr;
  logic [6:0] startLen;
  logic       clearReq;
  logic [7:0] byteIn;
  logic       byteValid;
  logic       byteReady;
  logic       busy;
  logic       done;
  logic [7:0] dataIn;
  logic       dataEn;
  logic       rs;

  plane_write_sequencer dut (
    .clk(clk), .reset(reset), .startValid(startValid), .startAddr(startAddr),
    .startLen(startLen), .clearReq(clearReq), .byteIn(byteIn),
    .byteValid(byteValid), .byteReady(byteReady), .busy(busy), .done(done),
    .dataIn(dataIn), .dataEn(dataEn), .rs(rs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_glitch = 0;

  logic [8:0] log_q[$];
  logic [7:0] mem_model[64];
  logic [5:0] mem_ptr;
  logic [7:0] burst_bytes[64];

  // Bus monitor: logs each transfer at the dataEn fall, updates the memory
  // model there, and counts strobe-width or data-stability violations.
  logic       m_prev_en;
  logic       m_started;
  int         m_hi;
  int         m_lo;
  logic [8:0] m_val;

  always @(negedge clk) begin
    if (!reset) begin
      m_prev_en = 1'b0;
      m_started = 1'b0;
      m_hi = 0;
      m_lo = 0;
    end else begin
      if (dataEn) begin
        if (!m_prev_en) begin
          if (m_started && m_lo < 2) n_glitch++;
          m_hi = 1;
          m_val = {rs, dataIn};
          m_started = 1'b1;
        end else begin
          m_hi++;
          if ({rs, dataIn} !== m_val) n_glitch++;
        end
      end else if (m_prev_en) begin
        if (m_hi != 2) n_glitch++;
        if ({rs, dataIn} !== m_val) n_glitch++;
        log_q.push_back(m_val);
        if (m_val[8]) begin
          if (m_val[7:0] == 8'h01) begin
            for (int i = 0; i < 64; i++) mem_model[i] = 8'h00;
            mem_ptr = 6'd0;
          end else if (m_val[7]) begin
            mem_ptr = m_val[5:0];
          end
        end else begin
          mem_model[mem_ptr] = m_val[7:0];
          mem_ptr = mem_ptr + 6'd1;
        end
        m_lo = 1;
      end else if (m_started) begin
        if (m_lo < 2 && {rs, dataIn} !== m_val) n_glitch++;
        if (m_lo < 100) m_lo++;
      end
      if (byteReady && (dataEn || !busy || done)) n_glitch++;
      m_prev_en = dataEn;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] get_log(input int i);
    if (i < log_q.size()) return log_q[i];
    return 9'bx;
  endfunction

  task automatic run_burst(input logic [5:0] a, input logic [6:0] len, input bit rnd,
                           input bit poke, output int done_cyc, output int dones,
                           output int first_rdy, output int nbytes);
    int idx;
    idx = 0; done_cyc = 0; dones = 0; first_rdy = 0;
    @(negedge clk);
    startAddr = a; startLen = len; startValid = 1'b1;
    @(posedge clk);
    for (int k = 1; k < 4000; k++) begin
      @(negedge clk);
      startValid = poke && (k == 3);
      if (poke && k == 3) begin
        startAddr = 6'h20;
        startLen  = 7'd5;
      end
      if (done) begin
        dones++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (byteReady && first_rdy == 0) first_rdy = k;
      if (done_cyc != 0 && k >= done_cyc + 3) break;
      byteValid = (idx < int'(len)) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      byteIn    = (idx < 64) ? burst_bytes[idx] : 8'h00;
      if (byteReady && byteValid) idx++;
    end
    byteValid = 1'b0;
    startValid = 1'b0;
    nbytes = idx;
  endtask

  int done_cyc, dones, first_rdy, nbytes, errs;

  initial begin
    reset = 1'b0; startValid = 1'b0; startAddr = '0; startLen = '0;
    clearReq = 1'b0; byteIn = '0; byteValid = 1'b0;
    mem_ptr = '0;
    for (int i = 0; i < 64; i++) mem_model[i] = 8'h00;

    // Reset state
    #2;
    chk("rst_dataEn", {31'd0, dataEn}, 0);
    chk("rst_rs", {31'd0, rs}, 0);
    chk("rst_dataIn", {24'd0, dataIn}, 0);
    chk("rst_busy_rdy_done", {29'd0, busy, byteReady, done}, 0);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_quiet", {29'd0, dataEn, busy, byteReady}, 0);

    // Burst addr 5, len 3, bytes fed immediately
    burst_bytes[0] = 8'h0A; burst_bytes[1] = 8'h0B; burst_bytes[2] = 8'h0C;
    log_q.delete();
    run_burst(6'd5, 7'd3, 1'b0, 1'b0, done_cyc, dones, first_rdy, nbytes);
    chk("b3_dones", dones, 1);
    chk("b3_done_cycle", done_cyc, 24);
    chk("b3_first_ready", first_rdy, 9);
    chk("b3_nbytes", nbytes, 3);
    chk("b3_log_size", log_q.size(), 5);
    chk("b3_log0", {23'd0, get_log(0)}, 32'h106);
    chk("b3_log1", {23'd0, get_log(1)}, 32'h185);
    chk("b3_log2", {23'd0, get_log(2)}, 32'h00A);
    chk("b3_log3", {23'd0, get_log(3)}, 32'h00B);
    chk("b3_log4", {23'd0, get_log(4)}, 32'h00C);
    chk("b3_mem", {8'd0, mem_model[5], mem_model[6], mem_model[7]}, 32'h000A0B0C);
    chk("b3_glitch", n_glitch, 0);

    // Clear and start together: clear wins
    log_q.delete();
    @(negedge clk);
    clearReq = 1'b1; startValid = 1'b1; startAddr = 6'd9; startLen = 7'd3;
    @(negedge clk);
    clearReq = 1'b0; startValid = 1'b0;
    chk("clr_first_cycle", {22'd0, busy, dataEn, rs, dataIn}, {22'd0, 3'b111, 8'h01});
    done_cyc = 0;
    for (int k = 2; k < 60; k++) begin
      @(negedge clk);
      if (done && done_cyc == 0) done_cyc = k;
      if (done_cyc != 0 && k >= done_cyc + 3) break;
    end
    chk("clr_done_cycle", done_cyc, 5);
    chk("clr_log_size", log_q.size(), 1);
    chk("clr_log0", {23'd0, get_log(0)}, 32'h101);
    chk("clr_mem5", {24'd0, mem_model[5]}, 32'h00);

    // Zero-length burst
    log_q.delete();
    run_burst(6'd3, 7'd0, 1'b0, 1'b0, done_cyc, dones, first_rdy, nbytes);
    chk("len0_done_cycle", done_cyc, 1);
    chk("len0_dones", dones, 1);
    chk("len0_log_size", log_q.size(), 0);

    // Full 64-byte burst from address 10 with random byteValid
    for (int i = 0; i < 64; i++) burst_bytes[i] = 8'(i * 7 + 3);
    log_q.delete();
    run_burst(6'd10, 7'd64, 1'b1, 1'b0, done_cyc, dones, first_rdy, nbytes);
    chk("b64_dones", dones, 1);
    chk("b64_nbytes", nbytes, 64);
    chk("b64_log_size", log_q.size(), 66);
    chk("b64_addr_cmd", {23'd0, get_log(1)}, 32'h18A);
    errs = 0;
    for (int i = 0; i < 64; i++)
      if (get_log(i + 2) !== {1'b0, 8'(i * 7 + 3)}) errs++;
    chk("b64_data_order", errs, 0);
    errs = 0;
    for (int i = 0; i < 64; i++)
      if (mem_model[6'(10 + i)] !== 8'(i * 7 + 3)) errs++;
    chk("b64_mem", errs, 0);
    chk("b64_glitch", n_glitch, 0);

    // startValid pulsed while busy is ignored
    burst_bytes[0] = 8'h55; burst_bytes[1] = 8'hAA;
    log_q.delete();
    run_burst(6'h30, 7'd2, 1'b0, 1'b1, done_cyc, dones, first_rdy, nbytes);
    chk("poke_dones", dones, 1);
    chk("poke_done_cycle", done_cyc, 19);
    chk("poke_log_size", log_q.size(), 4);
    chk("poke_addr_cmd", {23'd0, get_log(1)}, 32'h1B0);
    chk("poke_mem", {16'd0, mem_model[6'h30], mem_model[6'h31]}, 32'h55AA);

    // Reset asserted during the ADDR strobe
    @(negedge clk);
    startAddr = 6'd1; startLen = 7'd2; startValid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      startValid = 1'b0;
    end
    chk("addr_strobe_live", {23'd0, dataEn, rs, dataIn}, {23'd0, 2'b11, 8'h81});
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_dataEn", {31'd0, dataEn}, 0);
    chk("rst_mid_idle", {29'd0, busy, byteReady, rs}, 0);
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_after", {30'd0, dataEn, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plane_write_sequencer.md
Name: plane_write_sequencer

Overview:
- Bus master that sequences writes into the LED-plane PWM controller's byte-wide memory interface (dataIn/dataEn/rs, latched on the falling edge of dataEn).
- Accepts a burst request (start address and length) plus a byte stream from the host/MCU side, or a clear request.
- Emits the command and data strobes with guaranteed setup and hold: auto-increment command, set-address command, then N data writes.
- Sits between the frame source and the plane controller.

Parameters:
- D_WIDTH, 8, plane bus data width.
- A_WIDTH, 6, plane memory address width (64 outputs).
- STROBE_HI, 2, cycles dataEn is held high per transfer (legal range 1..15).
- STROBE_LO, 2, cycles dataEn is held low after each fall, with dataIn/rs held (legal range 1..15).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- startValid, input, 1, burst request strobe.
- startAddr, input, A_WIDTH, first memory address.
- startLen, input, A_WIDTH+1, byte count, 0..64.
- clearReq, input, 1, request memory-clear command.
- byteIn, input, D_WIDTH, burst data byte.
- byteValid, input, 1, byteIn valid.
- byteReady, output, 1, sequencer accepts byteIn this cycle.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle pulse at end of burst or clear.
- dataIn, output, D_WIDTH, plane bus data (registered).
- dataEn, output, 1, plane bus strobe (registered).
- rs, output, 1, plane bus select: 1 = command, 0 = data (registered).

Behaviour:
- Reset (async, active-low): state IDLE; dataEn=0, rs=0, dataIn=0, byteReady=0, busy=0, done=0; counters cleared. Reset mid-transfer forces dataEn low immediately, and the target may latch the partial byte. Recovery is host-initiated via clear or rewrite.
- States: IDLE, CLR, INC, ADDR, WAIT, DATA, DONE.
- IDLE transitions:
  - clearReq=1: go to CLR.
  - Else startValid=1: latch addr/len. Go to DONE if len=0, else INC.
  - clearReq and startValid together: clear wins, start is dropped.
  - Requests in any state other than IDLE are ignored.
- Transfer primitive (CLR/INC/ADDR/DATA):
  - First cycle: dataIn, rs and dataEn=1 all driven.
  - dataEn stays high for STROBE_HI cycles, then low for STROBE_LO cycles.
  - dataIn and rs are stable for the full STROBE_HI+STROBE_LO window.
  - Transfer length is STROBE_HI+STROBE_LO cycles, 4 with defaults.
- Command codes:
  - CLR: rs=1, 8'h01.
  - INC: rs=1, 8'h06 (increment mode).
  - ADDR: rs=1, 8'h80 | startAddr.
- Sequencing:
  - CLR -> DONE.
  - INC -> ADDR -> WAIT.
  - In WAIT, byteReady=1. A handshake (byteValid & byteReady) captures byteIn and moves to DATA. The next cycle has dataEn=1, rs=0, dataIn=byte.
  - After DATA, decrement the remaining count. Go to WAIT if nonzero, else DONE.
  - byteReady is 0 in every state except WAIT. No byte is consumed outside WAIT.
- DONE: lasts 1 cycle; done=1, busy=0; then IDLE.
- busy: 1 in CLR, INC, ADDR, WAIT, DATA.
- Start latency (defaults): startValid sampled at edge 0.
  - INC dataEn high in cycles 1–2.
  - ADDR dataEn high in cycles 5–6.
  - byteReady high from cycle 9.
- Address wrap past 63 is handled by the target's counter. The sequencer does no checking.
- len=64 is legal. The length counter is A_WIDTH+1 bits wide.
- Stalls: byteValid low in WAIT holds WAIT indefinitely, with bus outputs idle (dataEn=0) and dataIn/rs unchanged.

Test Plan:
- Reset released, no requests -> dataEn/busy/byteReady stay 0. Assert reset during ADDR strobe -> dataEn=0 in the same cycle, state IDLE.
- startAddr=5, len=3, bytes 0x0A/0x0B/0x0C fed immediately -> bus sees rs=1 0x06, rs=1 0x85, then rs=0 0x0A, 0x0B, 0x0C. Each dataEn high 2 cycles and low 2 cycles, with data stable throughout. done pulses once; total length 5×4+1 cycles plus 3 WAIT cycles.
- clearReq with startValid in the same cycle -> exactly one transfer rs=1 0x01, then done. No INC/ADDR is issued.
- len=0 -> no dataEn activity; done one cycle after start.
- len=64 with byteValid toggling randomly -> exactly 64 data strobes in order, no dropped or duplicated bytes, byteReady only in WAIT.
- startValid pulsed while busy -> ignored; the burst completes unchanged.
- Scoreboard: a model of the plane memory (falling-edge latch) matches the written bytes.
